// File: rtl/branch_ctrl_pkg.sv
// Shared definitions for the branch resolution / prediction slice.
package branch_ctrl_pkg;

  localparam int unsigned BHT_ENTRIES_DEF = 16;

  // Conditional branch funct3 encodings
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Weakly not taken
  localparam logic [1:0] BHT_RST = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FLUSH1,
    ST_FLUSH2
  } state_t;

  // 010/011 are not branch encodings: they resolve as not taken but never mispredict
  function automatic logic f3_is_branch(input logic [2:0] f3);
    return f3[2:1] != 2'b01;
  endfunction

endpackage

// File: rtl/branch_ctrl_if.sv
// Fetch/EX-side signal bundle for branch_ctrl.
interface branch_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [31:0]      if_pc_i;
  logic             pred_taken_o;
  logic             ex_valid_i;
  logic             ex_stall_i;
  logic [2:0]       ex_funct3_i;
  logic [31:0]      ex_pc_i;
  logic [31:0]      ex_target_i;
  logic             ex_pred_taken_i;
  logic             br_unsign_o;
  logic             br_less_i;
  logic             br_equal_i;
  logic             redirect_o;
  logic [31:0]      redirect_pc_o;
  logic             flush_o;
  logic [CNT_W-1:0] br_count_o;
  logic [CNT_W-1:0] mispred_count_o;

  modport master (
    output if_pc_i, ex_valid_i, ex_stall_i, ex_funct3_i, ex_pc_i, ex_target_i,
           ex_pred_taken_i, br_less_i, br_equal_i,
    input  pred_taken_o, br_unsign_o, redirect_o, redirect_pc_o, flush_o,
           br_count_o, mispred_count_o
  );

  modport slave (
    input  if_pc_i, ex_valid_i, ex_stall_i, ex_funct3_i, ex_pc_i, ex_target_i,
           ex_pred_taken_i, br_less_i, br_equal_i,
    output pred_taken_o, br_unsign_o, redirect_o, redirect_pc_o, flush_o,
           br_count_o, mispred_count_o
  );

endinterface

// File: rtl/branch_ctrl_bht_2bit.sv
// Array of 2-bit saturating branch history counters.
// One combinational read port, one synchronous update port, no read bypass.
module bht_2bit
  import branch_ctrl_pkg::*;
#(
  parameter  int unsigned ENTRIES = BHT_ENTRIES_DEF,
  localparam int unsigned IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [1:0]       rd_cnt,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  logic [1:0] cnt [ENTRIES];

  assign rd_cnt = cnt[rd_idx];

  // Saturating counter update on resolution
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < ENTRIES; i++) cnt[i] <= BHT_RST;
    end else if (upd_en) begin
      if (upd_taken && cnt[upd_idx] != 2'b11)
        cnt[upd_idx] <= cnt[upd_idx] + 2'd1;
      else if (!upd_taken && cnt[upd_idx] != 2'b00)
        cnt[upd_idx] <= cnt[upd_idx] - 2'd1;
    end
  end

endmodule

// File: rtl/branch_ctrl.sv
// Branch resolution, mispredict redirect/flush sequencing and statistics.
module branch_ctrl
  import branch_ctrl_pkg::*;
#(
  parameter int unsigned BHT_ENTRIES = BHT_ENTRIES_DEF,
  parameter int unsigned CNT_W       = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  branch_ctrl_if.slave bus
);

  localparam int unsigned IDX = $clog2(BHT_ENTRIES);

  state_t           state, state_nxt;
  logic             taken;
  logic             resolve;
  logic             mispred;
  logic [1:0]       rd_cnt;
  logic             redirect_q;
  logic [31:0]      redirect_pc_q;
  logic [CNT_W-1:0] br_cnt_q;
  logic [CNT_W-1:0] mis_cnt_q;

  bht_2bit #(
    .ENTRIES (BHT_ENTRIES)
  ) u_bht (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .rd_idx    (bus.if_pc_i[IDX+1:2]),
    .rd_cnt    (rd_cnt),
    .upd_en    (resolve),
    .upd_idx   (bus.ex_pc_i[IDX+1:2]),
    .upd_taken (taken)
  );

  // Branch outcome decode from funct3 and comparator flags
  always_comb begin
    taken = 1'b0;
    case (bus.ex_funct3_i)
      F3_BEQ:           taken = bus.br_equal_i;
      F3_BNE:           taken = !bus.br_equal_i;
      F3_BLT, F3_BLTU:  taken = bus.br_less_i;
      F3_BGE, F3_BGEU:  taken = !bus.br_less_i;
      default:          taken = 1'b0;
    endcase
  end

  assign resolve = bus.ex_valid_i && !bus.ex_stall_i && (state == ST_IDLE);
  assign mispred = resolve && f3_is_branch(bus.ex_funct3_i) &&
                   (taken != bus.ex_pred_taken_i);

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state: two flush cycles after each mispredict
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (mispred) state_nxt = ST_FLUSH1;
      ST_FLUSH1: state_nxt = ST_FLUSH2;
      ST_FLUSH2: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Redirect pulse and target; target holds between mispredicts
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
    end else begin
      redirect_q <= mispred;
      if (mispred)
        redirect_pc_q <= taken ? bus.ex_target_i : bus.ex_pc_i + 32'd4;
    end
  end

  // Wrapping statistics counters
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      br_cnt_q  <= '0;
      mis_cnt_q <= '0;
    end else begin
      if (resolve) br_cnt_q  <= br_cnt_q + CNT_W'(1);
      if (mispred) mis_cnt_q <= mis_cnt_q + CNT_W'(1);
    end
  end

  assign bus.pred_taken_o    = rd_cnt[1];
  assign bus.br_unsign_o     = (bus.ex_funct3_i[2:1] == 2'b11);
  assign bus.redirect_o      = redirect_q;
  assign bus.redirect_pc_o   = redirect_pc_q;
  assign bus.flush_o         = (state != ST_IDLE);
  assign bus.br_count_o      = br_cnt_q;
  assign bus.mispred_count_o = mis_cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed testbench for branch_ctrl.
module tb_branch_ctrl;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  branch_ctrl_if #(.CNT_W(16)) bus ();

  branch_ctrl #(
    .BHT_ENTRIES (16),
    .CNT_W       (16)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic idle_inputs;
    bus.if_pc_i         = 32'h0;
    bus.ex_valid_i      = 1'b0;
    bus.ex_stall_i      = 1'b0;
    bus.ex_funct3_i     = 3'b000;
    bus.ex_pc_i         = 32'h0;
    bus.ex_target_i     = 32'h0;
    bus.ex_pred_taken_i = 1'b0;
    bus.br_less_i       = 1'b0;
    bus.br_equal_i      = 1'b0;
  endtask

  task automatic drive(input logic [2:0] f3, input logic eq, input logic lt, input logic pr,
                       input logic [31:0] pc, input logic [31:0] tgt);
    bus.ex_valid_i      = 1'b1;
    bus.ex_stall_i      = 1'b0;
    bus.ex_funct3_i     = f3;
    bus.br_equal_i      = eq;
    bus.br_less_i       = lt;
    bus.ex_pred_taken_i = pr;
    bus.ex_pc_i         = pc;
    bus.ex_target_i     = tgt;
  endtask

  task automatic apply_reset;
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle_inputs();
    bus.if_pc_i = 32'h20;
    #2;
    checks++; if (bus.flush_o !== 1'b0) begin errors++; $display("FAIL reset_flush got %b want 0", bus.flush_o); end
    checks++; if (bus.redirect_o !== 1'b0) begin errors++; $display("FAIL reset_redirect got %b want 0", bus.redirect_o); end
    checks++; if (bus.redirect_pc_o !== 32'h0) begin errors++; $display("FAIL reset_redirect_pc got %h want 0", bus.redirect_pc_o); end
    checks++; if (bus.br_count_o !== 16'd0) begin errors++; $display("FAIL reset_br_count got %0d want 0", bus.br_count_o); end
    checks++; if (bus.mispred_count_o !== 16'd0) begin errors++; $display("FAIL reset_mispred got %0d want 0", bus.mispred_count_o); end
    checks++; if (bus.pred_taken_o !== 1'b0) begin errors++; $display("FAIL reset_pred got %b want 0", bus.pred_taken_o); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_beq_mispredict;
    apply_reset();
    drive(3'b000, 1'b1, 1'b0, 1'b0, 32'h100, 32'h140);
    #1;
    checks++; if (bus.br_unsign_o !== 1'b0) begin errors++; $display("FAIL beq_unsign got %b want 0", bus.br_unsign_o); end
    @(posedge clk); #1;
    idle_inputs();
    checks++; if (bus.redirect_o !== 1'b1) begin errors++; $display("FAIL beq_redirect got %b want 1", bus.redirect_o); end
    checks++; if (bus.redirect_pc_o !== 32'h140) begin errors++; $display("FAIL beq_redirect_pc got %h want 140", bus.redirect_pc_o); end
    checks++; if (bus.flush_o !== 1'b1) begin errors++; $display("FAIL beq_flush_n1 got %b want 1", bus.flush_o); end
    checks++; if (bus.mispred_count_o !== 16'd1) begin errors++; $display("FAIL beq_mispred got %0d want 1", bus.mispred_count_o); end
    checks++; if (bus.br_count_o !== 16'd1) begin errors++; $display("FAIL beq_br_count got %0d want 1", bus.br_count_o); end
    @(posedge clk); #1;
    checks++; if (bus.redirect_o !== 1'b0) begin errors++; $display("FAIL beq_redirect_n2 got %b want 0", bus.redirect_o); end
    checks++; if (bus.flush_o !== 1'b1) begin errors++; $display("FAIL beq_flush_n2 got %b want 1", bus.flush_o); end
    checks++; if (bus.redirect_pc_o !== 32'h140) begin errors++; $display("FAIL beq_redirect_pc_hold got %h want 140", bus.redirect_pc_o); end
    @(posedge clk); #1;
    checks++; if (bus.flush_o !== 1'b0) begin errors++; $display("FAIL beq_flush_n3 got %b want 0", bus.flush_o); end
  endtask

  task automatic test_bltu_correct;
    apply_reset();
    drive(3'b110, 1'b0, 1'b0, 1'b0, 32'h80, 32'h200);
    bus.ex_stall_i = 1'b1;
    #1;
    checks++; if (bus.br_unsign_o !== 1'b1) begin errors++; $display("FAIL bltu_unsign got %b want 1", bus.br_unsign_o); end
    @(posedge clk); #1;
    checks++; if (bus.br_count_o !== 16'd0) begin errors++; $display("FAIL bltu_stall_count got %0d want 0", bus.br_count_o); end
    bus.ex_stall_i = 1'b0;
    @(posedge clk); #1;
    idle_inputs();
    checks++; if (bus.redirect_o !== 1'b0) begin errors++; $display("FAIL bltu_redirect got %b want 0", bus.redirect_o); end
    checks++; if (bus.flush_o !== 1'b0) begin errors++; $display("FAIL bltu_flush got %b want 0", bus.flush_o); end
    checks++; if (bus.br_count_o !== 16'd1) begin errors++; $display("FAIL bltu_br_count got %0d want 1", bus.br_count_o); end
    checks++; if (bus.mispred_count_o !== 16'd0) begin errors++; $display("FAIL bltu_mispred got %0d want 0", bus.mispred_count_o); end
  endtask

  task automatic test_saturation;
    apply_reset();
    bus.if_pc_i = 32'h20;
    drive(3'b000, 1'b1, 1'b0, 1'b1, 32'h20, 32'h60);
    #1;
    checks++; if (bus.pred_taken_o !== 1'b0) begin errors++; $display("FAIL sat_no_bypass got %b want 0", bus.pred_taken_o); end
    // counter 1 -> 2 -> 3 -> 3 -> 3
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checks++; if (bus.pred_taken_o !== 1'b1) begin errors++; $display("FAIL sat_up%0d got %b want 1", i, bus.pred_taken_o); end
    end
    // funct3 010 decrements: 3 -> 2 keeps MSB, 2 -> 1 clears it
    bus.ex_funct3_i = 3'b010;
    @(posedge clk); #1;
    checks++; if (bus.pred_taken_o !== 1'b1) begin errors++; $display("FAIL sat_down1 got %b want 1", bus.pred_taken_o); end
    @(posedge clk); #1;
    checks++; if (bus.pred_taken_o !== 1'b0) begin errors++; $display("FAIL sat_down2 got %b want 0", bus.pred_taken_o); end
    idle_inputs();
    checks++; if (bus.br_count_o !== 16'd6) begin errors++; $display("FAIL sat_br_count got %0d want 6", bus.br_count_o); end
    checks++; if (bus.mispred_count_o !== 16'd0) begin errors++; $display("FAIL sat_mispred got %0d want 0", bus.mispred_count_o); end
    checks++; if (bus.flush_o !== 1'b0) begin errors++; $display("FAIL sat_flush got %b want 0", bus.flush_o); end
  endtask

  task automatic test_hold_during_flush;
    apply_reset();
    drive(3'b101, 1'b0, 1'b0, 1'b0, 32'h40, 32'h400);
    @(posedge clk); #1;
    checks++; if (bus.br_count_o !== 16'd1) begin errors++; $display("FAIL hold_br_n1 got %0d want 1", bus.br_count_o); end
    checks++; if (bus.redirect_pc_o !== 32'h400) begin errors++; $display("FAIL hold_redirect_pc got %h want 400", bus.redirect_pc_o); end
    @(posedge clk); #1;
    checks++; if (bus.redirect_o !== 1'b0) begin errors++; $display("FAIL hold_redirect_n2 got %b want 0", bus.redirect_o); end
    @(posedge clk); #1;
    idle_inputs();
    checks++; if (bus.br_count_o !== 16'd1) begin errors++; $display("FAIL hold_br_n3 got %0d want 1", bus.br_count_o); end
    checks++; if (bus.mispred_count_o !== 16'd1) begin errors++; $display("FAIL hold_mispred got %0d want 1", bus.mispred_count_o); end
    checks++; if (bus.flush_o !== 1'b0) begin errors++; $display("FAIL hold_flush_end got %b want 0", bus.flush_o); end
  endtask

  task automatic test_reset_in_flush;
    apply_reset();
    drive(3'b000, 1'b1, 1'b0, 1'b1, 32'h0, 32'h80);
    @(posedge clk); #1;
    drive(3'b001, 1'b1, 1'b0, 1'b1, 32'h4, 32'h90);
    @(posedge clk); #1;
    idle_inputs();
    checks++; if (bus.flush_o !== 1'b1) begin errors++; $display("FAIL rif_flush_pre got %b want 1", bus.flush_o); end
    rst = 1'b1;
    #1;
    checks++; if (bus.flush_o !== 1'b0) begin errors++; $display("FAIL rif_flush got %b want 0", bus.flush_o); end
    checks++; if (bus.redirect_o !== 1'b0) begin errors++; $display("FAIL rif_redirect got %b want 0", bus.redirect_o); end
    checks++; if (bus.redirect_pc_o !== 32'h0) begin errors++; $display("FAIL rif_redirect_pc got %h want 0", bus.redirect_pc_o); end
    checks++; if (bus.br_count_o !== 16'd0) begin errors++; $display("FAIL rif_br_count got %0d want 0", bus.br_count_o); end
    checks++; if (bus.mispred_count_o !== 16'd0) begin errors++; $display("FAIL rif_mispred got %0d want 0", bus.mispred_count_o); end
    for (int i = 0; i < 16; i++) begin
      bus.if_pc_i = 32'(i) << 2;
      #0.1;
      checks++; if (bus.pred_taken_o !== 1'b0) begin errors++; $display("FAIL rif_pred_idx%0d got %b want 0", i, bus.pred_taken_o); end
    end
    @(negedge clk);
    rst = 1'b0;
    drive(3'b000, 1'b1, 1'b0, 1'b0, 32'h200, 32'h300);
    @(posedge clk); #1;
    idle_inputs();
    checks++; if (bus.redirect_o !== 1'b1) begin errors++; $display("FAIL rif_after_redirect got %b want 1", bus.redirect_o); end
    checks++; if (bus.redirect_pc_o !== 32'h300) begin errors++; $display("FAIL rif_after_pc got %h want 300", bus.redirect_pc_o); end
    @(posedge clk);
    @(posedge clk); #1;
  endtask

  task automatic test_nonbranch_and_wrap;
    apply_reset();
    drive(3'b010, 1'b1, 1'b1, 1'b1, 32'h10, 32'h500);
    @(posedge clk); #1;
    checks++; if (bus.redirect_o !== 1'b0) begin errors++; $display("FAIL nb_redirect got %b want 0", bus.redirect_o); end
    checks++; if (bus.flush_o !== 1'b0) begin errors++; $display("FAIL nb_flush got %b want 0", bus.flush_o); end
    checks++; if (bus.mispred_count_o !== 16'd0) begin errors++; $display("FAIL nb_mispred got %0d want 0", bus.mispred_count_o); end
    checks++; if (bus.br_count_o !== 16'd1) begin errors++; $display("FAIL nb_br_count got %0d want 1", bus.br_count_o); end
    drive(3'b000, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'h1234);
    @(posedge clk); #1;
    idle_inputs();
    checks++; if (bus.redirect_o !== 1'b1) begin errors++; $display("FAIL wrap_redirect got %b want 1", bus.redirect_o); end
    checks++; if (bus.redirect_pc_o !== 32'h0) begin errors++; $display("FAIL wrap_redirect_pc got %h want 00000000", bus.redirect_pc_o); end
    checks++; if (bus.mispred_count_o !== 16'd1) begin errors++; $display("FAIL wrap_mispred got %0d want 1", bus.mispred_count_o); end
    @(posedge clk);
    @(posedge clk); #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_beq_mispredict();
    test_bltu_correct();
    test_saturation();
    test_hold_during_flush();
    test_reset_in_flush();
    test_nonbranch_and_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_ctrl.md
BRANCH_CTRL -- requirements
Module: branch_ctrl

Interface
REQ-001 Parameter BHT_ENTRIES, default 16, number of 2-bit branch history counters (power of two, 4..64).
REQ-002 Parameter CNT_W, default 16, width of the statistics counters.
REQ-003 clk_i  input  1  sole clock; all state updates on the rising edge.
REQ-004 rst_i  input  1  asynchronous, active-high reset.
REQ-005 if_pc_i  input  32  fetch-stage PC, used for the prediction lookup.
REQ-006 pred_taken_o  output  1  combinational prediction for if_pc_i: MSB of counter[if_pc_i[IDX+1:2]].
REQ-007 ex_valid_i  input  1  EX stage holds a valid conditional branch.
REQ-008 ex_stall_i  input  1  EX is frozen this cycle.
REQ-009 ex_funct3_i  input  3  branch funct3 of the EX instruction.
REQ-010 ex_pc_i  input  32  PC of the EX branch.
REQ-011 ex_target_i  input  32  computed branch target.
REQ-012 ex_pred_taken_i  input  1  prediction made at fetch for this branch, piped down.
REQ-013 br_unsign_o  output  1  comparator mode: 1 when ex_funct3_i is 110 or 111, else 0 (combinational).
REQ-014 br_less_i / br_equal_i  input  1 each  comparator results for the EX operands.
REQ-015 redirect_o  output  1  registered one-cycle pulse: fetch must load redirect_pc_o.
REQ-016 redirect_pc_o  output  32  registered correct next PC.
REQ-017 flush_o  output  1  squash the IF/ID and ID/EX contents; high while FSM is not IDLE.
REQ-018 br_count_o / mispred_count_o  output  CNT_W each  resolved branches / mispredicts, wrapping.

Function
REQ-019 Taken decode: 000 equal; 001 not equal; 100 and 110 less; 101 and 111 not less; 010/011 not taken, never counted as a mispredict.
REQ-020 Resolution occurs in a cycle where ex_valid_i=1, ex_stall_i=0 and FSM=IDLE; no other cycle resolves.
REQ-021 On resolution, the indexed counter saturates up when taken (max 3) and down when not taken (min 0); br_count_o increments.
REQ-022 A mispredict is a taken value that differs from ex_pred_taken_i; it increments mispred_count_o.
REQ-023 For a mispredict in cycle N, redirect_o=1 in cycle N+1 only, with redirect_pc_o = ex_target_i if taken, else ex_pc_i+4 (mod 2^32).
REQ-024 FSM states are IDLE, FLUSH1 and FLUSH2: IDLE->FLUSH1 on mispredict, FLUSH1->FLUSH2, FLUSH2->IDLE; flush_o=1 in FLUSH1 and FLUSH2 (cycles N+1 and N+2).
REQ-025 In FLUSH1/FLUSH2, all ex_* inputs are ignored: no counter, BHT or statistics update.
REQ-026 A correct prediction causes no redirect and no flush; the FSM stays IDLE.
REQ-027 On a same-cycle read and write of one BHT index, pred_taken_o returns the pre-update value (no bypass).
REQ-028 redirect_pc_o holds its last value when redirect_o=0.

Reset
REQ-029 rst_i asserted at any time forces, asynchronously, FSM=IDLE, redirect_o=0, redirect_pc_o=0, flush_o=0, both statistics counters=0, and all BHT counters=2'b01 (weakly not taken).
REQ-030 Reset during FLUSH1/FLUSH2 abandons the flush; the first cycle after release behaves as IDLE.

Structure
REQ-031 A shared package holds the funct3 branch encodings, the FSM state type, the BHT counter reset constant and the default BHT_ENTRIES.
REQ-032 A single sub-module, bht_2bit (counter array: one combinational read port, one synchronous update port), is instantiated once; decode, FSM and counters stay in branch_ctrl.

Verification
REQ-033 BEQ, equal=1, pred=0, pc=0x100, target=0x140 -> redirect_o=1 at N+1, redirect_pc_o=0x140, flush_o high N+1..N+2, mispred_count_o=1.
REQ-034 BLTU, less=0, pred=0 -> br_unsign_o=1, no redirect, no flush, br_count_o=1, mispred_count_o=0.
REQ-035 Four taken resolutions at pc=0x20 from reset -> counter goes 1,2,3,3; pred_taken_o for if_pc_i=0x20 turns 1 after the first update.
REQ-036 BGE resolved in cycle N with ex_valid_i=1 held through N+1 and N+2 -> only cycle N counts; br_count_o=1.
REQ-037 rst_i asserted in FLUSH1 -> flush_o=0 and counters=0 immediately; pred_taken_o=0 for every index.
REQ-038 funct3=010 with pred=1 -> no redirect, no mispredict; pc=0xFFFFFFFC not-taken mispredict -> redirect_pc_o=0x00000000.
